// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: latency classes and default result latencies shared by decode and the hazard scoreboard.
package hazard_scoreboard_pkg;
   typedef enum logic [1:0] {LAT_ALU, LAT_LOAD, LAT_MUL, LAT_DIV} lat_class_t;
   localparam int LOAD_LAT_DEF = 2;
   localparam int MUL_LAT_DEF  = 3;
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one architectural register's fixed-latency countdown and divider-busy bit.
module hazard_sb_entry #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reload_i,
   input  logic [CNT_W-1:0] reload_val_i,
   input  logic             set_i,
   input  logic             clr_i,
   input  logic             squash_i,
   output logic             pend_o,
   output logic             dbusy_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dbusy_q, dbusy_d;
   always_comb begin
      cnt_d   = squash_i ? '0 : reload_i ? reload_val_i : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      dbusy_d = squash_i ? 1'b0 : set_i ? 1'b1 : clr_i ? 1'b0 : dbusy_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         dbusy_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         dbusy_q <= dbusy_d;
      end
   end
   assign pend_o  = cnt_q != '0;
   assign dbusy_o = dbusy_q;
   // Only one divide is ever in flight, so its issue and completion never target the same bit together.
   set_clr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(set_i && clr_i));
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW/WAW/structural hazard detection from a per-register scoreboard,
// with a saturating stall-cycle counter.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_RS   = 2,
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int MUL_LAT  = MUL_LAT_DEF,
   parameter int PERF_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_d,
   input  logic [4:0]             rd_d,
   input  logic                   rd_used_d,
   input  lat_class_t             class_d,
   input  logic [NUM_RS-1:0][4:0] rs_d,
   input  logic [NUM_RS-1:0]      rs_used_d,
   input  logic                   div_done,
   input  logic [4:0]             div_rd,
   input  logic                   squash,
   output logic                   flag,
   output logic                   stall,
   output logic                   flush,
   output logic                   div_busy,
   output logic [PERF_W-1:0]      stall_cnt
);
   localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   logic [31:0]       pend, dbusy;
   logic              raw, waw, struct_hz, hz, issue;
   logic [CNT_W-1:0]  reload_val;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   // x0 is hardwired ready, so index 0 of the lookup vectors is a constant zero.
   assign pend[0]    = 1'b0;
   assign dbusy[0]   = 1'b0;
   assign reload_val = (class_d == LAT_LOAD) ? CNT_W'(LOAD_LAT) : CNT_W'(MUL_LAT);
   for (genvar g = 1; g < 32; g++) begin : g_entry
      hazard_sb_entry #(.CNT_W(CNT_W)) u_entry (
         .clk          (clk),
         .rst_n        (rst_n),
         .reload_i     (issue && rd_d == 5'(g) && (class_d == LAT_LOAD || class_d == LAT_MUL)),
         .reload_val_i (reload_val),
         .set_i        (issue && rd_d == 5'(g) && class_d == LAT_DIV),
         .clr_i        (div_done && div_rd == 5'(g)),
         .squash_i     (squash),
         .pend_o       (pend[g]),
         .dbusy_o      (dbusy[g])
      );
   end
   always_comb begin
      raw = 1'b0;
      for (int i = 0; i < NUM_RS; i++) raw = raw | (rs_used_d[i] & (pend[rs_d[i]] | dbusy[rs_d[i]]));
      waw         = rd_used_d & dbusy[rd_d];
      struct_hz   = (class_d == LAT_DIV) & div_busy;
      hz          = valid_d & ~squash & (raw | waw | struct_hz);
      issue       = valid_d & ~hz & ~squash & rd_used_d & (rd_d != 5'd0);
      stall_cnt_d = (hz && stall_cnt_q != '1) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end
   assign div_busy  = |dbusy;
   assign flag      = hz;
   assign stall     = hz;
   assign flush     = hz;
   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked against a ready-time reference model.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;
   localparam int LL = 2;
   localparam int ML = 3;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   logic valid_d, rd_used_d, div_done, squash;
   logic [4:0] rd_d, div_rd;
   lat_class_t class_d;
   logic [1:0][4:0] rs_d;
   logic [1:0] rs_used_d;
   logic flag, stall, flush, div_busy;
   logic [31:0] stall_cnt;
   logic v3, rdu3, dd3, sq3;
   logic [4:0] rd3, drd3;
   lat_class_t cls3;
   logic [2:0][4:0] rs3;
   logic [2:0] ru3;
   logic f3, s3, fl3, db3;
   logic [31:0] sc3;
   hazard_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rd_d(rd_d), .rd_used_d(rd_used_d), .class_d(class_d),
      .rs_d(rs_d), .rs_used_d(rs_used_d), .div_done(div_done), .div_rd(div_rd), .squash(squash),
      .flag(flag), .stall(stall), .flush(flush), .div_busy(div_busy), .stall_cnt(stall_cnt)
   );
   hazard_scoreboard #(.NUM_RS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .valid_d(v3), .rd_d(rd3), .rd_used_d(rdu3), .class_d(cls3),
      .rs_d(rs3), .rs_used_d(ru3), .div_done(dd3), .div_rd(drd3), .squash(sq3),
      .flag(f3), .stall(s3), .flush(fl3), .div_busy(db3), .stall_cnt(sc3)
   );
   int checks = 0;
   int failures = 0;
   longint cyc = 0;
   longint ready_at[32];
   bit divp[32];
   int unsigned mstall;

   function automatic bit m_busy();
      bit b = 1'b0;
      for (int r = 1; r < 32; r++) b |= divp[r];
      return b;
   endfunction

   function automatic bit m_hz();
      bit r = 1'b0;
      for (int i = 0; i < 2; i++)
         if (rs_used_d[i] && rs_d[i] != 0 && (cyc < ready_at[rs_d[i]] || divp[rs_d[i]])) r = 1'b1;
      if (rd_used_d && rd_d != 0 && divp[rd_d]) r = 1'b1;
      if (class_d == LAT_DIV && m_busy()) r = 1'b1;
      return valid_d && !squash && r;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 32; r++) begin ready_at[r] = 0; divp[r] = 1'b0; end
   endtask

   task automatic idle();
      valid_d = 0; rd_used_d = 0; rd_d = 0; class_d = LAT_ALU; rs_d = '0; rs_used_d = '0;
      div_done = 0; div_rd = 0; squash = 0;
   endtask

   task automatic set_ins(input logic v, input lat_class_t c, input logic [4:0] rd, input logic rdu,
                          input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
      idle();
      valid_d = v; class_d = c; rd_d = rd; rd_used_d = rdu;
      rs_d[0] = a; rs_used_d[0] = ua; rs_d[1] = b; rs_used_d[1] = ub;
   endtask

   // Advance one clock, updating the reference model with what the current D inputs should commit.
   task automatic cycle();
      bit h = m_hz();
      if (h && mstall != 32'hffff_ffff) mstall++;
      if (squash) m_clear();
      else begin
         if (div_done && div_rd != 0) divp[div_rd] = 1'b0;
         if (valid_d && !h && rd_used_d && rd_d != 0) begin
            if (class_d == LAT_LOAD) ready_at[rd_d] = cyc + LL + 1;
            if (class_d == LAT_MUL)  ready_at[rd_d] = cyc + ML + 1;
            if (class_d == LAT_DIV)  divp[rd_d] = 1'b1;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic reset_dut();
      rst_n = 0; idle(); v3 = 0;
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      cyc++; m_clear(); mstall = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle(); v3 = 0; rdu3 = 0; rd3 = 0; cls3 = LAT_ALU; rs3 = '0; ru3 = '0; dd3 = 0; drd3 = 0; sq3 = 0;
      #3;
      checks++; if (flag !== 1'b0) begin failures++; $display("FAIL rst_flag got=%b exp=0", flag); end
      checks++; if (stall !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b/%b exp=0/0", stall, flush); end
      checks++; if (div_busy !== 1'b0) begin failures++; $display("FAIL rst_div_busy got=%b exp=0", div_busy); end
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
      reset_dut();
   endtask

   task automatic test_load_use();
      reset_dut();
      set_ins(1, LAT_LOAD, 5, 1, 0, 0, 0, 0); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_issue stall got=%b exp=0", stall); end
      cycle();
      for (int k = 0; k < 3; k++) begin
         set_ins(1, LAT_ALU, 6, 1, 5, 1, 1, 1); #1;
         checks++; if (stall !== (k < 2) || flush !== (k < 2)) begin failures++; $display("FAIL lu_t%0d stall/flush got=%b/%b exp=%b", k + 1, stall, flush, k < 2); end
         cycle();
      end
      idle(); #1;
      checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL lu_cnt got=%0d exp=2", stall_cnt); end
      set_ins(1, LAT_LOAD, 5, 1, 0, 0, 0, 0); cycle();
      idle(); cycle();
      for (int k = 0; k < 2; k++) begin
         set_ins(1, LAT_ALU, 6, 1, 5, 1, 0, 0); #1;
         checks++; if (stall !== (k == 0)) begin failures++; $display("FAIL lu_gap%0d stall got=%b exp=%b", k, stall, k == 0); end
         cycle();
      end
   endtask

   task automatic test_x0_unused();
      reset_dut();
      set_ins(1, LAT_LOAD, 0, 1, 0, 0, 0, 0); cycle();
      set_ins(1, LAT_ALU, 3, 1, 0, 1, 0, 1); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_user stall got=%b exp=0", stall); end
      cycle();
      set_ins(1, LAT_LOAD, 5, 1, 0, 0, 0, 0); cycle();
      set_ins(1, LAT_ALU, 3, 1, 5, 0, 5, 0); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL unused_rs stall got=%b exp=0", stall); end
      set_ins(1, LAT_ALU, 3, 1, 1, 1, 5, 1); #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL used_rs1 stall got=%b exp=1", stall); end
      cycle();
   endtask

   task automatic test_mul();
      reset_dut();
      set_ins(1, LAT_MUL, 7, 1, 0, 0, 0, 0); cycle();
      set_ins(1, LAT_ALU, 2, 1, 3, 1, 4, 1); cycle();
      for (int k = 0; k < 3; k++) begin
         set_ins(1, LAT_ALU, 8, 1, 7, 1, 0, 0); #1;
         checks++; if (stall !== (k < 2)) begin failures++; $display("FAIL mul_t%0d stall got=%b exp=%b", k, stall, k < 2); end
         cycle();
      end
      idle(); #1;
      checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL mul_cnt got=%0d exp=2", stall_cnt); end
      set_ins(1, LAT_MUL, 7, 1, 0, 0, 0, 0); cycle();
      idle(); cycle();
      idle(); cycle();
      set_ins(1, LAT_LOAD, 7, 1, 1, 1, 0, 0); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reload_issue stall got=%b exp=0", stall); end
      cycle();
      for (int k = 0; k < 3; k++) begin
         set_ins(1, LAT_ALU, 8, 1, 0, 0, 7, 1); #1;
         checks++; if (stall !== (k < 2)) begin failures++; $display("FAIL reload_t%0d stall got=%b exp=%b", k, stall, k < 2); end
         cycle();
      end
   endtask

   task automatic test_div();
      reset_dut();
      set_ins(1, LAT_DIV, 9, 1, 0, 0, 0, 0); cycle();
      for (int k = 0; k < 3; k++) begin
         set_ins(1, LAT_ALU, 4, 1, 9, 1, 0, 0); #1;
         checks++; if (stall !== 1'b1 || div_busy !== 1'b1) begin failures++; $display("FAIL div_wait%0d stall/busy got=%b/%b exp=1/1", k, stall, div_busy); end
         cycle();
      end
      set_ins(1, LAT_DIV, 10, 1, 1, 1, 2, 1); #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL div_struct stall got=%b exp=1", stall); end
      cycle();
      set_ins(1, LAT_ALU, 9, 1, 1, 1, 0, 0); #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL div_waw stall got=%b exp=1", stall); end
      cycle();
      set_ins(1, LAT_ALU, 4, 1, 9, 1, 0, 0); div_done = 1; div_rd = 9; #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL div_done_cyc stall got=%b exp=1", stall); end
      cycle();
      set_ins(1, LAT_ALU, 4, 1, 9, 1, 0, 0); #1;
      checks++; if (stall !== 1'b0 || div_busy !== 1'b0) begin failures++; $display("FAIL div_after stall/busy got=%b/%b exp=0/0", stall, div_busy); end
      cycle();
   endtask

   task automatic test_squash();
      reset_dut();
      set_ins(1, LAT_LOAD, 5, 1, 0, 0, 0, 0); cycle();
      set_ins(1, LAT_LOAD, 6, 1, 5, 1, 0, 0); squash = 1; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sq_mask stall got=%b exp=0", stall); end
      cycle();
      set_ins(1, LAT_ALU, 3, 1, 5, 1, 6, 1); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sq_after stall got=%b exp=0", stall); end
      cycle();
   endtask

   task automatic test_async_reset();
      reset_dut();
      set_ins(1, LAT_DIV, 9, 1, 0, 0, 0, 0); cycle();
      set_ins(1, LAT_LOAD, 5, 1, 0, 0, 0, 0); cycle();
      set_ins(1, LAT_ALU, 4, 1, 9, 1, 5, 1); #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ar_pre stall got=%b exp=1", stall); end
      #1 rst_n = 0; #1;
      checks++; if ({flag, stall, flush, div_busy} !== 4'b0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL ar_async flag/stall/flush/busy=%b%b%b%b cnt=%0d exp=0000/0", flag, stall, flush, div_busy, stall_cnt); end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      cyc++; m_clear(); mstall = 0;
      set_ins(1, LAT_ALU, 4, 1, 9, 1, 0, 0); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_after stall got=%b exp=0", stall); end
      cycle();
   endtask

   task automatic test_nrs3();
      reset_dut();
      v3 = 1; cls3 = LAT_LOAD; rd3 = 5; rdu3 = 1; rs3 = '0; ru3 = '0;
      @(posedge clk); #1;
      cls3 = LAT_ALU; rd3 = 6; rs3[0] = 1; rs3[1] = 2; rs3[2] = 5; ru3 = 3'b111; #1;
      checks++; if (s3 !== 1'b1) begin failures++; $display("FAIL nrs3_rs3 stall got=%b exp=1", s3); end
      ru3 = 3'b011; #1;
      checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL nrs3_unused stall got=%b exp=0", s3); end
      v3 = 0; ru3 = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      reset_dut();
      for (int n = 0; n < 600; n++) begin
         bit h;
         int dr;
         idle();
         valid_d = ($urandom_range(0, 3) != 0);
         class_d = lat_class_t'($urandom_range(0, 3));
         rd_d = 5'($urandom_range(0, 7)); rd_used_d = ($urandom_range(0, 5) != 0);
         rs_d[0] = 5'($urandom_range(0, 7)); rs_d[1] = 5'($urandom_range(0, 7));
         rs_used_d = 2'($urandom_range(0, 3));
         squash = ($urandom_range(0, 39) == 0);
         dr = 0;
         for (int r = 1; r < 32; r++) if (divp[r]) dr = r;
         if (dr != 0 && $urandom_range(0, 4) == 0) begin div_done = 1; div_rd = 5'(dr); end
         #1;
         h = m_hz();
         checks++; if (stall !== h || flush !== h || flag !== h) begin failures++; $display("FAIL rnd%0d hz stall/flush/flag got=%b%b%b exp=%b", n, stall, flush, flag, h); end
         checks++; if (div_busy !== m_busy()) begin failures++; $display("FAIL rnd%0d div_busy got=%b exp=%b", n, div_busy, m_busy()); end
         checks++; if (stall_cnt !== mstall) begin failures++; $display("FAIL rnd%0d stall_cnt got=%0d exp=%0d", n, stall_cnt, mstall); end
         cycle();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_x0_unused();
      test_mul();
      test_div();
      test_squash();
      test_async_reset();
      test_nrs3();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised decode-stage hazard unit that replaces fixed-stage load-use comparators with a per-register scoreboard.
- Tracks outstanding results by latency class: load, fixed-latency multiply, variable-latency divide.
- Stalls the instruction in D while any source it uses is not yet forwardable, and injects a bubble into E.
- Also covers WAW against the divider, a structural divider-busy check, and a saturating stall-cycle performance counter.

Parameters:
NUM_RS, 2, number of source-register read ports checked per decode instruction (3 for R4-type).
LOAD_LAT, 2, cycles a dependent instruction issued directly behind a load must wait (2 = load result forwardable from M2).
MUL_LAT, 3, wait cycles for a multiply result.
CNT_W, $clog2(max(LOAD_LAT,MUL_LAT)+1), countdown width (derived, not overridden).
PERF_W, 32, width of the stall counter.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
valid_d  input  1  valid instruction in D
rd_d  input  5  destination of D instruction
rd_used_d  input  1  D instruction writes rd
class_d  input  lat_class_t  latency class of D instruction
rs_d  input  NUM_RS x 5  source registers of D instruction
rs_used_d  input  NUM_RS  per-port source-valid
div_done  input  1  divider writes back this cycle
div_rd  input  5  divider destination at writeback
squash  input  1  pipeline squash (trap/redirect); aborts divider
flag  output  1  hazard present (perf/debug)
stall  output  1  hold F and D
flush  output  1  bubble into E
div_busy  output  1  a divide is outstanding
stall_cnt  output  PERF_W  saturating count of stall cycles

Behaviour:
- State:
  - cnt[1..31], CNT_W bits each.
  - dbusy[1..31], 1 bit each.
  - stall_cnt.
  - x0 is never tracked; register 0 always reads as ready.
- Reset (async, rst_n=0): all cnt=0, all dbusy=0, stall_cnt=0.
- Outputs at reset: flag=0, stall=0, flush=0, div_busy=0.
- Hazard evaluation is combinational from registered state and D inputs, zero latency:
  - raw = OR over i of (rs_used_d[i] & rs_d[i]!=0 & (cnt[rs_d[i]]!=0 | dbusy[rs_d[i]])).
  - waw = rd_used_d & rd_d!=0 & dbusy[rd_d].
  - struct = class_d==LAT_DIV & div_busy.
  - hz = valid_d & !squash & (raw | waw | struct).
  - flag = stall = flush = hz.
- div_busy = OR of dbusy.
- Issue: issue = valid_d & !hz & !squash & rd_used_d & rd_d!=0. On issue:
  - LAT_LOAD: cnt[rd_d] <= LOAD_LAT.
  - LAT_MUL: cnt[rd_d] <= MUL_LAT.
  - LAT_DIV: dbusy[rd_d] <= 1.
  - LAT_ALU: no change (EX forwarding covers it).
- Every cycle, each nonzero cnt not being reloaded decrements by 1 and saturates at 0.
- A reload on the same register in the same cycle takes priority over the decrement.
- Timing: a load issued at cycle t makes a dependent in D at t+1 stall at t+1 and t+2 and issue at t+3, i.e. LOAD_LAT bubbles. The dependent at t+2 stalls once.
- Divider completion: div_done clears dbusy[div_rd] on the next edge.
  - A set and a clear of the same dbusy bit in the same cycle cannot occur: WAW and struct forbid it. This is an assertion, not a priority rule.
- squash: on the next edge, all cnt and all dbusy clear. squash also masks issue and hz in the same cycle.
  - An instruction already past E when squash arrives is not protected. Squash is only legal when every younger-than-committed result is discarded.
- stall_cnt increments when hz=1 and saturates at all-ones; there is no wrap.
- No state change occurs while valid_d=0 except decrement, div_done, and squash.

Decomposition:
- riscv_defines gains:
  - lat_class_t enum {LAT_ALU, LAT_LOAD, LAT_MUL, LAT_DIV}.
  - LOAD_LAT_DEF and MUL_LAT_DEF constants.
- The decoder drives class_d.
- One sub-module, hazard_sb_entry: one register's cnt and dbusy, with reload, decrement, clear and squash. It is instantiated 31 times by generate.
- The top-level module holds the NUM_RS read-port mux, hazard OR and perf counter.

Test Plan:
1. Load x5 at t, then add x6,x5,x1 in D at t+1 -> stall=flush=1 at t+1 and t+2, 0 at t+3; stall_cnt=2.
2. Load x0 followed by a user of x0 -> no stall; also rs_used_d=0 on a matching register -> no stall.
3. MUL x7 (MUL_LAT=3), independent instruction, then user of x7 -> exactly 2 stall cycles; reload x7 by a load while cnt[x7]=1 -> cnt becomes 2 and the reload wins.
4. DIV x9 issued, user of x9 waits until div_done with div_rd=9, then issues the cycle after the clear; second DIV during busy -> struct stall; write to x9 while busy -> waw stall.
5. Load x5 followed by squash in the next cycle -> all cnt cleared, stall=0 on the following user, and issue is masked during the squash cycle.
6. Assert rst_n low mid-division with cnt values nonzero -> all outputs 0 immediately (async); after release, a user of x9 issues without stall; NUM_RS=3 build with rs3=x5 after a load -> stalls.
